// File: rtl/sqrt_sched_pkg.sv
// Shared types and width helpers for the round-robin integer square-root scheduler.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    RESP
  } state_e;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned ID_W        = $clog2(DEF_NUM_REQ);
  localparam int unsigned ROOT_W      = DEF_WIDTH / 2;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_newton_step.sv
// One combinational Newton-Raphson step for integer sqrt: x_next = (x + num/x) / 2.
module sqrt_newton_step
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] x_next,
  output logic             converged
);

  logic [WIDTH-1:0] w_quot;
  logic [WIDTH:0]   w_sum;

  // The sum carries one extra bit so x + num/x cannot wrap before halving.
  always_comb begin
    w_quot    = (x == '0) ? '0 : num / x;
    w_sum     = {1'b0, x} + {1'b0, w_quot};
    x_next    = w_sum[WIDTH:1];
    converged = (x_next >= x);
  end

endmodule

// File: rtl/sqrt_sched.sv
// Round-robin scheduler sharing one iterative Newton-Raphson sqrt datapath.
// Optional macro SQRT_REM_EN adds the resp_rem remainder output.
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_ITER = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]         req_num,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [WIDTH/2-1:0]               resp_root,
  output logic [clog2_min1(NUM_REQ)-1:0]   resp_id,
  output logic                             resp_err,
`ifdef SQRT_REM_EN
  output logic [WIDTH/2:0]                 resp_rem,
`endif
  output logic                             busy
);

  localparam int unsigned IDW = clog2_min1(NUM_REQ);
  localparam int unsigned RW  = WIDTH / 2;
  localparam int unsigned ITW = clog2_min1(MAX_ITER);

  state_e           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_x;
  logic [ITW-1:0]   r_iter;

  logic             w_gnt_found;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_idx;
  logic [WIDTH-1:0] w_sel_num;
  logic [WIDTH-1:0] w_x_next;
  logic             w_conv;
  logic [RW-1:0]    w_sat;

  sqrt_newton_step #(.WIDTH(WIDTH)) u_step (
    .num      (r_num),
    .x        (r_x),
    .x_next   (w_x_next),
    .converged(w_conv)
  );

  // Round-robin search starting at r_rr_ptr, wrapping around.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_gnt_found && req_valid[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_num = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_id == IDW'(k)) w_sel_num = req_num[k*WIDTH +: WIDTH];
    end
  end

  // Grant is offered only in IDLE and is forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_gnt_found && !rst) req_ready[w_gnt_id] = 1'b1;
  end

  assign w_sat = (r_x[WIDTH-1:RW] != '0) ? '1 : r_x[RW-1:0];

`ifdef SQRT_REM_EN
  logic [RW:0] w_rem;
  assign w_rem = (RW+1)'(r_num - r_x * r_x);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_num      <= '0;
      r_x        <= '0;
      r_iter     <= '0;
      resp_valid <= 1'b0;
      resp_root  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
`ifdef SQRT_REM_EN
      resp_rem   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_found) begin
            r_num    <= w_sel_num;
            r_x      <= w_sel_num;
            r_iter   <= '0;
            r_id     <= w_gnt_id;
            r_rr_ptr <= (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
            busy     <= 1'b1;
            if (w_sel_num == '0) begin
              resp_root  <= '0;
              resp_id    <= w_gnt_id;
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
`ifdef SQRT_REM_EN
              resp_rem   <= '0;
`endif
              r_state    <= RESP;
            end else begin
              r_state <= ITER;
            end
          end
        end
        ITER: begin
          if (w_conv) begin
            resp_root  <= r_x[RW-1:0];
            resp_id    <= r_id;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
`ifdef SQRT_REM_EN
            resp_rem   <= w_rem;
`endif
            r_state    <= RESP;
          end else if (r_iter == ITW'(MAX_ITER - 1)) begin
            resp_root  <= w_sat;
            resp_id    <= r_id;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
`ifdef SQRT_REM_EN
            resp_rem   <= '0;
`endif
            r_state    <= RESP;
          end else begin
            r_x    <= w_x_next;
            r_iter <= r_iter + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_sched.sv
// Directed scoreboard bench for sqrt_sched; a second instance runs with MAX_ITER=2.
module tb_sqrt_sched;
  import sqrt_sched_pkg::*;

  localparam int unsigned NR = DEF_NUM_REQ;
  localparam int unsigned W  = DEF_WIDTH;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ROOT_W-1:0] root;
    logic              err;
    logic [ROOT_W:0]   rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NR-1:0]     req_valid  = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_num    = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [ROOT_W-1:0] resp_root;
  logic [ID_W-1:0]   resp_id;
  logic              resp_err;
  logic              busy;

  logic [NR-1:0]     req_valid2 = '0;
  logic [NR-1:0]     req_ready2;
  logic [NR*W-1:0]   req_num2   = '0;
  logic              resp_valid2;
  logic [ROOT_W-1:0] resp_root2;
  logic [ID_W-1:0]   resp_id2;
  logic              resp_err2;
  logic              busy2;
`ifdef SQRT_REM_EN
  logic [ROOT_W:0]   resp_rem;
  logic [ROOT_W:0]   resp_rem2;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sqrt_sched u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_num(req_num),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_root(resp_root), .resp_id(resp_id), .resp_err(resp_err),
`ifdef SQRT_REM_EN
    .resp_rem(resp_rem),
`endif
    .busy(busy)
  );

  sqrt_sched #(.MAX_ITER(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_num(req_num2),
    .resp_valid(resp_valid2), .resp_ready(1'b1),
    .resp_root(resp_root2), .resp_id(resp_id2), .resp_err(resp_err2),
`ifdef SQRT_REM_EN
    .resp_rem(resp_rem2),
`endif
    .busy(busy2)
  );

  // Reference root by linear search, independent of the Newton iteration.
  function automatic logic [ROOT_W-1:0] isqrt(input logic [W-1:0] n);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= 32'(n)) r++;
    return ROOT_W'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, wait for its grant, record the expected result, cross the accept edge.
  task automatic grant(input int id, input logic [W-1:0] num, input bit keep);
    int   n = 0;
    exp_t e;
    req_valid[id]      = 1'b1;
    req_num[id*W +: W] = num;
    #1;
    while (!req_ready[id] && n < 200) begin
      step();
      n++;
    end
    check("grant_onehot", 32'(req_ready), 32'(1) << id);
    e.id   = ID_W'(id);
    e.root = isqrt(num);
    e.err  = 1'b0;
    e.rem  = (ROOT_W+1)'(32'(num) - 32'(e.root) * 32'(e.root));
    sb.push_back(e);
    step();
    if (!keep) req_valid[id] = 1'b0;
  endtask

  // Called one cycle after the accept edge; exp_lat=0 skips the latency check.
  task automatic wait_resp(input string tag, input int exp_lat);
    int   n = 1;
    exp_t e;
    while (!resp_valid && n < 200) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_rdy_held"}, 32'(req_ready), 32'd0);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_root"}, 32'(resp_root), 32'(e.root));
      check({tag, "_id"}, 32'(resp_id), 32'(e.id));
      check({tag, "_err"}, 32'(resp_err), 32'(e.err));
`ifdef SQRT_REM_EN
      check({tag, "_rem"}, 32'(resp_rem), 32'(e.rem));
`endif
    end
    if (resp_ready) begin
      step();
      check({tag, "_done"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    int n;
    int id;
    logic [W-1:0] num;

    // Reset: outputs zero and no grant even with every requester valid
    req_valid = '1;
    step(); step(); step();
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_root", 32'(resp_root), 32'd0);
    check("rst_id", 32'(resp_id), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    step();

    // Single request, x sequence 16,8,5,4
    grant(0, 16'd16, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_resp("t1", 5);

    // Zero, one and full-scale radicands
    grant(2, 16'd0, 1'b0);
    wait_resp("t2_zero", 1);
    grant(3, 16'd1, 1'b0);
    wait_resp("t2_one", 0);
    grant(3, 16'hFFFF, 1'b0);
    wait_resp("t2_max", 0);

    // Iteration cap on the MAX_ITER=2 instance saturates the root
    req_valid2 = 4'b0001;
    req_num2[W-1:0] = 16'hFFFF;
    #1;
    check("t5_ready", 32'(req_ready2), 32'd1);
    step();
    req_valid2 = '0;
    n = 1;
    while (!resp_valid2 && n < 50) begin
      step();
      n++;
    end
    check("t5_valid", 32'(resp_valid2), 32'd1);
    check("t5_lat", 32'(n), 32'd3);
    check("t5_err", 32'(resp_err2), 32'd1);
    check("t5_root", 32'(resp_root2), 32'd255);
    check("t5_id", 32'(resp_id2), 32'd0);
`ifdef SQRT_REM_EN
    check("t5_rem", 32'(resp_rem2), 32'd0);
`endif
    step();
    check("t5_done", 32'(resp_valid2), 32'd0);

    // All requesters valid: round-robin 0,1,2,3,0
    req_valid = '1;
    req_num   = {16'd900, 16'd300, 16'd35, 16'd49};
    grant(0, 16'd49, 1'b1);
    wait_resp("t3_g0", 0);
    grant(1, 16'd35, 1'b1);
    wait_resp("t3_g1", 0);
    grant(2, 16'd300, 1'b1);
    wait_resp("t3_g2", 0);
    grant(3, 16'd900, 1'b1);
    wait_resp("t3_g3", 0);
    grant(0, 16'd49, 1'b1);
    wait_resp("t3_g0b", 0);
    req_valid = '0;

    // Random radicands on random requesters
    for (int i = 0; i < 6; i++) begin
      id  = int'($urandom_range(0, NR - 1));
      num = W'($urandom_range(0, 65535));
      grant(id, num, 1'b0);
      wait_resp("rnd", 0);
    end

    // Backpressure: response held, no new grant while stalled
    resp_ready = 1'b0;
    grant(1, 16'd100, 1'b0);
    wait_resp("t4a", 0);
    req_valid[2]      = 1'b1;
    req_num[2*W +: W] = 16'd50;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t4_hold_valid", 32'(resp_valid), 32'd1);
      check("t4_hold_root", 32'(resp_root), 32'd10);
      check("t4_hold_id", 32'(resp_id), 32'd1);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    check("t4_release_valid", 32'(resp_valid), 32'd0);
    check("t4_release_grant", 32'(req_ready), 32'b0100);
    grant(2, 16'd50, 1'b0);
    wait_resp("t4b", 0);

    // Reset mid-ITER drops the job and restarts the pointer at 0
    grant(1, 16'd60000, 1'b0);
    step();
    step();
    check("t6_busy", 32'(busy), 32'd1);
    req_valid[0]      = 1'b1;
    req_num[0 +: W]   = 16'd81;
    req_valid[2]      = 1'b1;
    req_num[2*W +: W] = 16'd200;
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(resp_valid), 32'd0);
    check("t6_root", 32'(resp_root), 32'd0);
    check("t6_id", 32'(resp_id), 32'd0);
    check("t6_err", 32'(resp_err), 32'd0);
    check("t6_busy0", 32'(busy), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    step();
    rst = 1'b0;
    #1;
    check("t6_first_grant", 32'(req_ready), 32'b0001);
    grant(0, 16'd81, 1'b0);
    wait_resp("t6a", 0);
    grant(2, 16'd200, 1'b0);
    wait_resp("t6b", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
